hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
//
// Detects load-use hazards between ID and EX, squashes wrong-path
// instructions on a taken branch, and freezes the front of the pipeline
// while a multi-cycle mul/div runs. A mul/div that never reports done
// within MD_TIMEOUT+1 wait cycles drops the controller into a sticky error
// state that only reset clears.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   id_rs1_i, id_rs2_i       ID-stage source registers
//   id_uses_rs1_i/rs2_i      ID instruction actually reads rs1/rs2
//   ex_mem_read_i, ex_rd_i   EX instruction is a load / its destination
//   ex_muldiv_start_i        EX instruction launches a mul/div
//   muldiv_done_i            mul/div result valid this cycle
//   ex_branch_taken_i        EX resolved a taken branch/jump
//   pc_stall_o .. id_ex_flush_o  pipeline hold / bubble / squash controls
//   state_o                  00 RUN, 01 MD_WAIT, 10 HALT_ERR
//   md_timeout_o             sticky mul/div timeout flag
//   stall_cycles_o           saturating count of cycles with pc_stall_o=1
module hazard_ctrl #(
  // Legal range 1..255; the wait counter is 8 bits wide.
  parameter int unsigned MD_TIMEOUT = 63
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_muldiv_start_i,
  input  logic        muldiv_done_i,
  input  logic        ex_branch_taken_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        id_ex_stall_o,
  output logic        id_ex_bubble_o,
  output logic        ex_mem_bubble_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic [1:0]  state_o,
  output logic        md_timeout_o,
  output logic [15:0] stall_cycles_o
);

  localparam logic [1:0] StRun     = 2'b00;
  localparam logic [1:0] StMdWait  = 2'b01;
  localparam logic [1:0] StHaltErr = 2'b10;

  localparam logic [7:0] TimeoutCnt = MD_TIMEOUT[7:0];

  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        md_timeout_q, md_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic load_use;

  // x0 never carries a real dependency, so it cannot cause a load-use stall.
  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    md_timeout_d    = md_timeout_q;
    pc_stall_o      = 1'b0;
    if_id_stall_o   = 1'b0;
    id_ex_stall_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_bubble_o = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;

    if (!rst_i) begin
      case (state_q)
        StRun: begin
          if (ex_branch_taken_i) begin
            // Wrong-path ID instruction is squashed, so its hazard is moot.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (load_use && !ex_muldiv_start_i) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
          end
          if (ex_muldiv_start_i) begin
            state_d    = StMdWait;
            wait_cnt_d = 8'd0;
          end
        end
        StMdWait: begin
          if (muldiv_done_i) begin
            state_d = StRun;
          end else begin
            pc_stall_o      = 1'b1;
            if_id_stall_o   = 1'b1;
            id_ex_stall_o   = 1'b1;
            ex_mem_bubble_o = 1'b1;
            if (wait_cnt_q == TimeoutCnt) begin
              md_timeout_d = 1'b1;
              state_d      = StHaltErr;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end
        end
        StHaltErr: begin
          pc_stall_o      = 1'b1;
          if_id_stall_o   = 1'b1;
          id_ex_stall_o   = 1'b1;
          ex_mem_bubble_o = 1'b1;
        end
        default: begin
          // Unreachable encoding: recover to RUN.
          state_d = StRun;
        end
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (pc_stall_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StRun;
      wait_cnt_q   <= 8'd0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign state_o        = rst_i ? StRun : state_q;
  assign md_timeout_o   = md_timeout_q;
  assign stall_cycles_o = stall_cnt_q;

endmodule
